// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: opcodes, fetch FSM states, default reset PC.
package instr_fetch_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a new instruction, flush invalidates it.
module if_id_reg #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] pc_plus4_in,
  input  logic [31:0]   instr_in,
  output logic          valid_out,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_plus4_out,
  output logic [31:0]   instr_out
);

  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]   instr_q, instr_d;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      instr_d    = instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid_out    = valid_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4_q;
  assign instr_out    = instr_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS instruction fetch stage: PC, imem req/ack FSM, hold buffer, IF/ID register.
// Optional performance counters built when IF_PERF_CNT_EN is defined.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [AW-1:0] if_pc_plus4,
  output logic [31:0]   if_instr,
  output logic [5:0]    instr_op,
  output logic [31:0]   perf_fetches,
  output logic [31:0]   perf_stalls
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] drain_addr_q, drain_addr_d;
  logic [AW-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]   hold_instr_q, hold_instr_d;

  logic          ifid_load;
  logic          ifid_flush;
  logic [AW-1:0] ifid_pc;
  logic [31:0]   ifid_instr;
  logic [AW-1:0] target_aligned;
  logic [AW-1:0] pc_next_seq;

  assign target_aligned = branch_target & ~AW'(3);
  assign pc_next_seq    = pc_q + AW'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_pc      = pc_q;
    ifid_instr   = imem_rdata;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (branch_taken) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // The request at pc_q is outstanding; without an ack it must be drained.
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
          if (!imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_next_seq;
          if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (branch_taken) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
        end else if (imem_ack) begin
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d         = target_aligned;
          ifid_flush   = 1'b1;
          hold_pc_d    = '0;
          hold_instr_d = '0;
          state_d      = ST_FETCH;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_pc    = hold_pc_q;
          ifid_instr = hold_instr_q;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= AW'(RESET_PC);
      drain_addr_q <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  if_id_reg #(
    .AW(AW)
  ) u_if_id_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (ifid_load),
    .flush        (ifid_flush),
    .pc_in        (ifid_pc),
    .pc_plus4_in  (ifid_pc + AW'(4)),
    .instr_in     (ifid_instr),
    .valid_out    (if_valid),
    .pc_out       (if_pc),
    .pc_plus4_out (if_pc_plus4),
    .instr_out    (if_instr)
  );

  assign instr_op = if_instr[31:26];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_stalls_d  = perf_stalls_q;
    if (ifid_load) perf_fetches_d = perf_fetches_q + 32'd1;
    if (stall && if_valid) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetches_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetches = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage (handshake, stall, redirect, reset, perf).
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic [5:0]  instr_op;
  logic [31:0] perf_fetches;
  logic [31:0] perf_stalls;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .AW      (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_pc_plus4  (if_pc_plus4),
    .if_instr     (if_instr),
    .instr_op     (instr_op),
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    #12;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_perf_f", perf_fetches, 32'd0);

    // release: one IDLE cycle, then FETCH at 0 with ack delayed 3 cycles
    tick();
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("dly_req", {31'd0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h0);
      chk("dly_valid", {31'd0, if_valid}, 32'd0);
      tick();
    end
    chk("dly_addr4", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0000;
    tick();
    chk("lw_valid", {31'd0, if_valid}, 32'd1);
    chk("lw_op", {26'd0, instr_op}, 32'h23);
    chk("lw_pc", if_pc, 32'h0);
    chk("lw_pc4", if_pc_plus4, 32'h4);
    chk("addr4", imem_addr, 32'h4);
    imem_rdata = 32'h0000_0020;
    tick();
    chk("r_op", {26'd0, instr_op}, 32'h00);
    chk("r_pc", if_pc, 32'h4);
    chk("addr8", imem_addr, 32'h8);
    imem_rdata = 32'hAC02_0004;
    tick();
    chk("sw_op", {26'd0, instr_op}, 32'h2B);
    chk("sw_pc4", if_pc_plus4, 32'hC);
    chk("addr12", imem_addr, 32'hC);

    // stall on ack -> HOLD
    stall = 1'b1; imem_rdata = 32'h1000_0004;
    tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_instr", if_instr, 32'hAC02_0004);
    chk("hold_pc", if_pc, 32'h8);
    imem_ack = 1'b0;
    tick();
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    chk("hold2_instr", if_instr, 32'hAC02_0004);
    stall = 1'b0;
    tick();
    chk("rel_instr", if_instr, 32'h1000_0004);
    chk("rel_op", {26'd0, instr_op}, 32'h04);
    chk("rel_pc", if_pc, 32'hC);
    chk("rel_addr", imem_addr, 32'h10);
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    // redirect from HOLD (no request pending)
    imem_ack = 1'b1; stall = 1'b1; imem_rdata = 32'h0000_0022;
    tick();
    chk("hold3_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0042;
    tick();
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_req", {31'd0, imem_req}, 32'd1);

    // redirect with request pending -> DRAIN
    stall = 1'b0; branch_target = 32'h0000_0082;
    tick();
    branch_taken = 1'b0;
    chk("drn_req", {31'd0, imem_req}, 32'd1);
    chk("drn_addr", imem_addr, 32'h40);
    chk("drn_valid", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("drn_drop", {31'd0, if_valid}, 32'd0);
    chk("drn_new", imem_addr, 32'h80);
    imem_rdata = 32'h2001_0005;
    tick();
    chk("addi_valid", {31'd0, if_valid}, 32'd1);
    chk("addi_op", {26'd0, instr_op}, 32'h08);
    chk("addi_pc", if_pc, 32'h80);

    // redirect + stall + ack together: redirect wins
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200; imem_rdata = 32'h8C00_0000;
    tick();
    chk("pri_valid", {31'd0, if_valid}, 32'd0);
    chk("pri_req", {31'd0, imem_req}, 32'd1);
    chk("pri_addr", imem_addr, 32'h200);

    // PC wrap at top of address space
    stall = 1'b0; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'h0000_0020;
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    // async reset mid-HOLD
    stall = 1'b1;
    tick();
    chk("h4_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_instr", if_instr, 32'd0);
    chk("ar_pc4", if_pc_plus4, 32'd0);
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    tick();
    chk("ar_addr", imem_addr, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("pf_pc", if_pc, 32'h24);
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0;
    tick();
`ifdef IF_PERF_CNT_EN
    chk("perf_f", perf_fetches, 32'd10);
    chk("perf_s", perf_stalls, 32'd3);
`else
    chk("perf_f", perf_fetches, 32'd0);
    chk("perf_s", perf_stalls, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
